// File: rtl/uvmt_dp_probe_pkg.sv
// rtl/uvmt_dp_probe_pkg.sv - shared types and defaults for the dp probe capture block
package uvmt_dp_probe_pkg;

    localparam int PROBE_NUM_CH = 4;
    localparam int PROBE_DATA_W = 8;
    localparam int PROBE_DEPTH  = 16;
    localparam int PROBE_TS_W   = 16;

    function automatic int ch_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int PROBE_CH_W = ch_width(PROBE_NUM_CH);

    typedef enum logic {
        PROBE_MODE_CHANGE   = 1'b0,
        PROBE_MODE_PERIODIC = 1'b1
    } probe_mode_e;

    typedef struct packed {
        logic [PROBE_CH_W-1:0]   ch;
        logic [PROBE_DATA_W-1:0] data;
        logic [PROBE_TS_W-1:0]   ts;
    } probe_entry_t;

endpackage

// File: rtl/uvmt_dp_probe_fifo.sv
// rtl/uvmt_dp_probe_fifo.sv - first-word-fall-through FIFO with occupancy output
module uvmt_dp_probe_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         head_data,
    output logic                     empty,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_LEVEL = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             do_push;
    logic             do_pop;

    assign empty     = (count == '0);
    assign full      = (count == FULL_LEVEL);
    assign level     = count;
    assign head_data = mem[rd_ptr];
    assign do_pop    = pop && !empty;
    // A full FIFO still accepts a write when the head leaves in the same cycle.
    assign do_push   = push && (!full || do_pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            if (do_push && !do_pop) begin
                count <= count + (AW + 1)'(1);
            end else if (do_pop && !do_push) begin
                count <= count - (AW + 1)'(1);
            end
        end
    end

endmodule

// File: rtl/uvmt_dp_probe_capture.sv
// rtl/uvmt_dp_probe_capture.sv - multi-channel probe recorder with pending slots, round-robin arbiter and FIFO
module uvmt_dp_probe_capture
    import uvmt_dp_probe_pkg::*;
#(
    parameter int  NUM_CH = PROBE_NUM_CH,
    parameter int  DATA_W = PROBE_DATA_W,
    parameter int  DEPTH  = PROBE_DEPTH,
    parameter int  TS_W   = PROBE_TS_W,
    localparam int CH_W   = ch_width(NUM_CH)
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic [NUM_CH*DATA_W-1:0]   probe_i,
    input  logic [NUM_CH-1:0]          ch_en_i,
    input  logic                       mode_i,
    input  logic [TS_W-1:0]            period_i,
    input  logic                       clr_ovf_i,
    output logic                       out_valid_o,
    input  logic                       out_ready_i,
    output logic [CH_W-1:0]            out_ch_o,
    output logic [DATA_W-1:0]          out_data_o,
    output logic [TS_W-1:0]            out_ts_o,
    output logic [NUM_CH-1:0]          ovf_o,
    output logic [$clog2(DEPTH):0]     level_o
);

    localparam int ENTRY_W = CH_W + DATA_W + TS_W;

    logic [TS_W-1:0]                ts_q;
    logic [TS_W-1:0]                per_cnt_q;
    logic [TS_W-1:0]                period_eff;
    logic                           prime_q;
    probe_mode_e                    mode_q;
    probe_mode_e                    mode_cur;
    logic                           mode_changed;
    logic                           per_tick;
    logic [NUM_CH-1:0][DATA_W-1:0]  prev_q;
    logic [NUM_CH-1:0][DATA_W-1:0]  slot_data_q;
    logic [NUM_CH-1:0][TS_W-1:0]    slot_ts_q;
    logic [NUM_CH-1:0]              slot_valid_q;
    logic [NUM_CH-1:0]              trig;
    logic [NUM_CH-1:0]              ovf_set;
    logic [NUM_CH-1:0]              ovf_q;
    logic [CH_W-1:0]                rr_ptr_q;
    logic [CH_W-1:0]                rr_next;
    logic [CH_W-1:0]                gnt_idx;
    logic                           gnt;
    logic                           fifo_empty;
    logic                           fifo_full;
    logic                           fifo_pop;
    logic [ENTRY_W-1:0]             push_word;
    logic [ENTRY_W-1:0]             head_word;

    assign mode_cur     = probe_mode_e'(mode_i);
    assign mode_changed = (mode_cur != mode_q);
    assign period_eff   = (period_i == '0) ? TS_W'(1) : period_i;
    // The cycle that switches mode only restarts the period counter.
    assign per_tick     = prime_q && (mode_cur == PROBE_MODE_PERIODIC) && !mode_changed
                          && (per_cnt_q >= period_eff - TS_W'(1));

    always_comb begin
        trig    = '0;
        ovf_set = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (prime_q && ch_en_i[c]) begin
                if (mode_cur == PROBE_MODE_PERIODIC) begin
                    trig[c] = per_tick;
                end else begin
                    trig[c] = (probe_i[c*DATA_W +: DATA_W] != prev_q[c]);
                end
            end
            ovf_set[c] = trig[c] && slot_valid_q[c] && !(gnt && (gnt_idx == CH_W'(c)));
        end
    end

    always_comb begin
        int              idx;
        logic [CH_W-1:0] cand;
        gnt     = 1'b0;
        gnt_idx = '0;
        idx     = 0;
        cand    = '0;
        if (!fifo_full || fifo_pop) begin
            for (int i = 0; i < NUM_CH; i++) begin
                idx = int'(rr_ptr_q) + i;
                if (idx >= NUM_CH) begin
                    idx = idx - NUM_CH;
                end
                cand = CH_W'(idx);
                if (!gnt && slot_valid_q[cand]) begin
                    gnt     = 1'b1;
                    gnt_idx = cand;
                end
            end
        end
    end

    assign rr_next     = (gnt_idx == CH_W'(NUM_CH - 1)) ? '0 : gnt_idx + CH_W'(1);
    assign out_valid_o = !fifo_empty;
    assign fifo_pop    = out_valid_o && out_ready_i;
    assign push_word   = {gnt_idx, slot_data_q[gnt_idx], slot_ts_q[gnt_idx]};
    assign out_ch_o    = head_word[ENTRY_W-1 -: CH_W];
    assign out_data_o  = head_word[TS_W +: DATA_W];
    assign out_ts_o    = head_word[TS_W-1:0];
    assign ovf_o       = ovf_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ts_q         <= '0;
            per_cnt_q    <= '0;
            prime_q      <= 1'b0;
            mode_q       <= PROBE_MODE_CHANGE;
            prev_q       <= '0;
            slot_valid_q <= '0;
            slot_data_q  <= '0;
            slot_ts_q    <= '0;
            rr_ptr_q     <= '0;
            ovf_q        <= '0;
        end else begin
            ts_q    <= ts_q + TS_W'(1);
            prime_q <= 1'b1;
            prev_q  <= probe_i;
            mode_q  <= mode_cur;
            if (mode_changed || (mode_cur != PROBE_MODE_PERIODIC)
                || (per_cnt_q >= period_eff - TS_W'(1))) begin
                per_cnt_q <= '0;
            end else begin
                per_cnt_q <= per_cnt_q + TS_W'(1);
            end
            if (gnt) begin
                rr_ptr_q <= rr_next;
            end
            // A new trigger always replaces the slot; the granted copy is already on its way out.
            for (int c = 0; c < NUM_CH; c++) begin
                if (trig[c]) begin
                    slot_valid_q[c] <= 1'b1;
                    slot_data_q[c]  <= probe_i[c*DATA_W +: DATA_W];
                    slot_ts_q[c]    <= ts_q;
                end else if (gnt && (gnt_idx == CH_W'(c))) begin
                    slot_valid_q[c] <= 1'b0;
                end
            end
            ovf_q <= (ovf_q & ~{NUM_CH{clr_ovf_i}}) | ovf_set;
        end
    end

    uvmt_dp_probe_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (reset_n),
        .push      (gnt),
        .push_data (push_word),
        .pop       (fifo_pop),
        .head_data (head_word),
        .empty     (fifo_empty),
        .full      (fifo_full),
        .level     (level_o)
    );

endmodule

// File: tb/tb_uvmt_dp_probe_capture.sv
// tb/tb_uvmt_dp_probe_capture.sv - scoreboard bench for the dp probe capture block
module tb_uvmt_dp_probe_capture;
    import uvmt_dp_probe_pkg::*;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [31:0] probe;
    logic [3:0]  ch_en;
    logic        mode;
    logic [15:0] period;
    logic        clr_ovf;
    logic        out_ready;
    logic        out_valid;
    logic [1:0]  out_ch;
    logic [7:0]  out_data;
    logic [15:0] out_ts;
    logic [3:0]  ovf;
    logic [4:0]  level;

    int           n_vec  = 0;
    int           n_miss = 0;
    probe_entry_t exp_q[$];
    probe_entry_t mon_e;
    logic [15:0]  cyc;

    uvmt_dp_probe_capture dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .probe_i     (probe),
        .ch_en_i     (ch_en),
        .mode_i      (mode),
        .period_i    (period),
        .clr_ovf_i   (clr_ovf),
        .out_valid_o (out_valid),
        .out_ready_i (out_ready),
        .out_ch_o    (out_ch),
        .out_data_o  (out_data),
        .out_ts_o    (out_ts),
        .ovf_o       (ovf),
        .level_o     (level)
    );

    always #5 clk = ~clk;

    // Reference timestamp: cycles since reset release, wrapping at 16 bits.
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) cyc <= '0;
        else          cyc <= cyc + 16'd1;
    end

    always @(negedge clk) begin
        if (reset_n && out_valid && out_ready) begin
            n_vec++;
            if (exp_q.size() == 0) begin
                n_miss++;
                $display("FAIL unexpected_entry: got ch=%0d data=%h ts=%h, required no entry", out_ch, out_data, out_ts);
            end else begin
                mon_e = exp_q.pop_front();
                if ({out_ch, out_data, out_ts} !== mon_e) begin
                    n_miss++;
                    $display("FAIL entry: got ch=%0d data=%h ts=%h, required ch=%0d data=%h ts=%h",
                             out_ch, out_data, out_ts, mon_e.ch, mon_e.data, mon_e.ts);
                end
            end
        end
    end

    initial begin
        #1_500_000;
        $display("FAIL watchdog: simulation time limit reached, required normal completion");
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss + 1);
        $fatal(1);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_ch(input int c, input logic [7:0] v);
        probe[c*8 +: 8] = v;
    endtask

    task automatic push_exp(input int c, input logic [7:0] v, input logic [15:0] ts);
        probe_entry_t e;
        e.ch   = 2'(c);
        e.data = v;
        e.ts   = ts;
        exp_q.push_back(e);
    endtask

    task automatic drain_wait(input string tag);
        int g = 0;
        while ((exp_q.size() != 0 || out_valid) && g < 200) begin
            step();
            g++;
        end
        n_vec++;
        if (exp_q.size() != 0 || out_valid !== 1'b0) begin
            n_miss++;
            $display("FAIL drain_%s: %0d entries outstanding, out_valid=%b, required 0 and 0", tag, exp_q.size(), out_valid);
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0; probe = 32'hA5C3_1F07; ch_en = 4'hF; mode = 1'b0;
        period = '0; clr_ovf = 1'b0; out_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_vec++; if (out_valid !== 1'b0) begin n_miss++; $display("FAIL rst_valid: got %b, required 0", out_valid); end
        n_vec++; if (out_ch !== 2'd0) begin n_miss++; $display("FAIL rst_ch: got %0d, required 0", out_ch); end
        n_vec++; if (out_data !== 8'h00) begin n_miss++; $display("FAIL rst_data: got %h, required 00", out_data); end
        n_vec++; if (out_ts !== 16'h0000) begin n_miss++; $display("FAIL rst_ts: got %h, required 0000", out_ts); end
        n_vec++; if (ovf !== 4'h0) begin n_miss++; $display("FAIL rst_ovf: got %b, required 0000", ovf); end
        n_vec++; if (level !== 5'd0) begin n_miss++; $display("FAIL rst_level: got %0d, required 0", level); end
        step();
        reset_n = 1'b1;
        repeat (6) begin
            @(negedge clk);
            n_vec++;
            if (level !== 5'd0 || out_valid !== 1'b0) begin
                n_miss++;
                $display("FAIL prime_no_event: got level=%0d valid=%b, required 0 and 0", level, out_valid);
            end
        end
        step();
        ch_en = 4'h0; probe = '0;
        step(); step();
        ch_en = 4'hF;
    endtask

    task automatic test_single_change();
        int g = 0;
        while (cyc != 16'h0010 && g < 200) begin step(); g++; end
        n_vec++;
        if (cyc !== 16'h0010) begin n_miss++; $display("FAIL ts_align: got %h, required 0010", cyc); end
        set_ch(2, 8'h5A);
        push_exp(2, 8'h5A, 16'h0010);
        @(posedge clk);
        @(negedge clk);
        n_vec++; if (out_valid !== 1'b0) begin n_miss++; $display("FAIL latency_k: got valid=%b, required 0", out_valid); end
        @(negedge clk);
        n_vec++; if (out_valid !== 1'b1) begin n_miss++; $display("FAIL latency_k1: got valid=%b, required 1", out_valid); end
        drain_wait("single");
    endtask

    task automatic test_all_change();
        step();
        set_ch(3, 8'h77);
        push_exp(3, 8'h77, cyc);
        drain_wait("ch3");
        step();
        probe = 32'h4433_2211;
        for (int c = 0; c < 4; c++) push_exp(c, 8'(8'h11 * (c + 1)), cyc);
        repeat (2) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            n_vec++;
            if (out_valid !== 1'b1) begin n_miss++; $display("FAIL b2b_valid_%0d: got %b, required 1", i, out_valid); end
        end
        drain_wait("all");
    endtask

    task automatic test_overflow();
        logic [15:0] ts0;
        logic [15:0] ts19;
        ts0 = '0; ts19 = '0;
        out_ready = 1'b0;
        for (int i = 0; i < 20; i++) begin
            step();
            set_ch(0, 8'h80 + 8'(i));
            if (i == 0)  ts0  = cyc;
            if (i == 19) ts19 = cyc;
            if (i < 16) push_exp(0, 8'h80 + 8'(i), cyc);
        end
        repeat (3) step();
        @(negedge clk);
        n_vec++; if (level !== 5'd16) begin n_miss++; $display("FAIL ovf_level: got %0d, required 16", level); end
        n_vec++; if (ovf !== 4'b0001) begin n_miss++; $display("FAIL ovf_flag: got %b, required 0001", ovf); end
        n_vec++; if (out_data !== 8'h80 || out_ts !== ts0) begin
            n_miss++; $display("FAIL hold_head: got data=%h ts=%h, required 80 %h", out_data, out_ts, ts0); end
        @(negedge clk);
        n_vec++; if (out_data !== 8'h80 || out_valid !== 1'b1) begin
            n_miss++; $display("FAIL hold_head2: got data=%h valid=%b, required 80 1", out_data, out_valid); end
        push_exp(0, 8'h93, ts19);
        step();
        clr_ovf = 1'b1;
        step();
        clr_ovf = 1'b0;
        @(negedge clk);
        n_vec++; if (ovf !== 4'b0000) begin n_miss++; $display("FAIL ovf_clear: got %b, required 0000", ovf); end
        step();
        out_ready = 1'b1;
        drain_wait("ovf");
    endtask

    task automatic test_periodic();
        logic [15:0] m;
        step();
        set_ch(3, 8'h3C);
        push_exp(3, 8'h3C, cyc);
        drain_wait("ptr0");
        step();
        mode = 1'b1; period = 16'd3; ch_en = 4'b0011;
        m = cyc;
        for (int j = 1; j <= 3; j++) begin
            push_exp(0, 8'h93, m + 16'(3 * j));
            push_exp(1, 8'h22, m + 16'(3 * j));
        end
        repeat (10) step();
        mode = 1'b0;
        drain_wait("per3");
        n_vec++; if (ovf !== 4'b0000) begin n_miss++; $display("FAIL per3_ovf: got %b, required 0000", ovf); end
        step();
        mode = 1'b1; period = 16'd0; ch_en = 4'b0001;
        m = cyc;
        for (int j = 1; j <= 5; j++) push_exp(0, 8'h93, m + 16'(j));
        repeat (6) step();
        mode = 1'b0;
        drain_wait("per0");
        n_vec++; if (ovf !== 4'b0000) begin n_miss++; $display("FAIL per0_ovf: got %b, required 0000", ovf); end
        ch_en = 4'hF;
    endtask

    task automatic test_wrap_and_reset();
        int g = 0;
        while (cyc != 16'hFFFF && g < 70000) begin step(); g++; end
        n_vec++;
        if (cyc !== 16'hFFFF) begin n_miss++; $display("FAIL wrap_align: got %h, required ffff", cyc); end
        set_ch(1, 8'hE1);
        push_exp(1, 8'hE1, 16'hFFFF);
        step();
        set_ch(1, 8'hE2);
        push_exp(1, 8'hE2, 16'h0000);
        drain_wait("wrap");
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            set_ch(0, 8'hC0 + 8'(i));
        end
        repeat (3) step();
        n_vec++; if (level !== 5'd5 || out_valid !== 1'b1) begin
            n_miss++; $display("FAIL pre_reset: got level=%0d valid=%b, required 5 1", level, out_valid); end
        reset_n = 1'b0;
        #1;
        n_vec++; if (out_valid !== 1'b0) begin n_miss++; $display("FAIL async_rst_valid: got %b, required 0", out_valid); end
        n_vec++; if (level !== 5'd0) begin n_miss++; $display("FAIL async_rst_level: got %0d, required 0", level); end
        n_vec++; if (out_data !== 8'h00 || out_ts !== 16'h0) begin
            n_miss++; $display("FAIL async_rst_data: got data=%h ts=%h, required 00 0000", out_data, out_ts); end
        step();
        reset_n = 1'b1;
        repeat (4) step();
        n_vec++; if (level !== 5'd0) begin n_miss++; $display("FAIL post_reset_level: got %0d, required 0", level); end
    endtask

    initial begin
        test_reset();
        test_single_change();
        test_all_change();
        test_overflow();
        test_periodic();
        test_wrap_and_reset();
        n_vec++;
        if (exp_q.size() != 0) begin
            n_miss++;
            $display("FAIL leftover: got %0d expected entries never produced, required 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/uvmt_dp_probe_capture.md
# uvmt_dp_probe_capture

Parametrised, multi-channel probe capture block for the dp testbench. Samples NUM_CH probed design-hierarchy buses every clock and records change events (or periodic samples) as timestamped entries in a small FIFO, read out over a valid/ready stream by the environment monitor. It replaces the passive signal bundle with a self-contained recorder that has its own arbitration, buffering and overflow reporting.

## Interface
Parameters:
- NUM_CH, 4, number of probed channels (1..16)
- DATA_W, 8, width of each channel's probed bus
- DEPTH, 16, FIFO entries (power of two, >= 2)
- TS_W, 16, timestamp counter width

Ports:
- Reset is asynchronous and active-low; one clock.
- clk  in  1  sole clock, all state on rising edge
- reset_n  in  1  asynchronous active-low reset
- probe_i  in  NUM_CH*DATA_W  probed buses; channel c occupies bits [c*DATA_W +: DATA_W]
- ch_en_i  in  NUM_CH  per-channel capture enable
- mode_i  in  1  0 = change capture, 1 = periodic sample
- period_i  in  TS_W  periodic interval in cycles; 0 treated as 1
- clr_ovf_i  in  1  one-cycle pulse, clears ovf_o
- out_valid_o  out  1  FIFO head valid
- out_ready_i  in  1  consumer accepts head
- out_ch_o  out  $clog2(NUM_CH) (min 1)  channel of head entry
- out_data_o  out  DATA_W  captured value
- out_ts_o  out  TS_W  timestamp of capture
- ovf_o  out  NUM_CH  sticky per-channel lost-event flags
- level_o  out  $clog2(DEPTH)+1  FIFO occupancy

## Operation
- ts_q: free-running counter, +1 every cycle, wraps 2^TS_W-1 -> 0.
- prime_q: cleared by reset; first cycle after reset release loads prev_q <= probe_i, sets prime_q, generates no events.
- Change mode: channel c triggers at edge when ch_en_i[c] and probe_i[c] != prev_q[c]; prev_q always updates to probe_i.
- Periodic mode: per_cnt counts 0..max(period_i,1)-1; at terminal count every enabled channel triggers regardless of value; per_cnt reset to 0 on mode_i change.
- Trigger loads channel's pending slot {valid=1, data=probe_i[c], ts=ts_q}.
- Trigger on channel whose slot is valid and not granted that cycle: slot overwritten with newest, ovf_o[c] set.
- Trigger on channel granted same cycle: granted entry goes to FIFO, new entry becomes pending, no overflow.
- Arbiter: round-robin over valid slots, one grant per cycle, only when FIFO not full or popped that cycle; pointer advances to granted+1.
- Disabling ch_en_i[c] does not clear a valid slot; it drains normally.
- FIFO: first-word-fall-through; pop when out_valid_o && out_ready_i; push and pop same cycle allowed at any level including full.
- clr_ovf_i clears ovf_o; a set in the same cycle wins.

## Timing
- Reset values: out_valid_o=0, out_ch_o=0, out_data_o=0, out_ts_o=0, ovf_o=0, level_o=0; ts_q, per_cnt, slots, pointers, prime_q all 0.
- Trigger at edge k -> slot valid after k -> FIFO push at edge k+1 (if granted) -> out_valid_o high after k+1; out_ts_o equals ts_q value before edge k.
- Backpressure: out_ready_i low holds head stable; out_* change only after an accepted pop or a push into empty FIFO.
- Reset asserted mid-operation: all entries and pending slots discarded immediately; outputs to reset values asynchronously.

## Structure
- Shared package uvmt_dp_probe_pkg: entry struct typedef {ch, data, ts} parametrised via localparams, mode enum (PROBE_MODE_CHANGE, PROBE_MODE_PERIODIC).
- Sub-module uvmt_dp_probe_fifo: generic FWFT FIFO (width, depth params, level output); top holds prime/compare, pending slots, arbiter, counters.

## Test plan
- Reset release with probe_i nonzero, mode 0, all enabled -> no entries; level_o stays 0.
- Channel 2 steps 0x00->0x5A at edge k, ts_q=0x0010 before edge -> one entry {ch=2, data=0x5A, ts=0x0010}, out_valid_o after edge k+1.
- All 4 channels change same cycle, out_ready_i=1 -> 4 entries over 4 cycles, order 0,1,2,3 (pointer at 0), identical ts.
- out_ready_i=0, channel 0 toggles every cycle for 20 cycles -> level_o saturates at 16, ovf_o[0]=1, last pending entry holds final value; clr_ovf_i pulse -> ovf_o=0.
- Mode 1, period_i=3, ch_en_i=4'b0011 -> entries for ch0, ch1 every 3 cycles with ts spaced by 3; period_i=0 -> trigger every cycle.
- ts_q wrap: event at ts 0xFFFF then next cycle -> out_ts_o 0xFFFF then 0x0000; reset_n pulse with FIFO holding 5 entries -> out_valid_o=0, level_o=0 immediately.
